br_issue_queue: RTL

//  In-order issue queue and scheduler for the single branch FU. Buffers

---
 rtl/br_issue_queue.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/br_issue_queue.sv
// rtl/br_issue_queue.sv - in-order branch issue queue with CDB wakeup, branch-mask squash and resolve
// Issues the oldest ready branch op to the PRF-read / branch-FU stage.
module br_issue_queue #(
   parameter int DEPTH     = 4,
   parameter int PRF_IDX_W = 6,
   parameter int ROB_IDX_W = 5,
   parameter int BR_MASK_W = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       disp_en_i,
   input  logic [63:0]                disp_npc_i,
   input  logic [31:0]                disp_inst_i,
   input  logic [PRF_IDX_W-1:0]       disp_dest_tag_i,
   input  logic [PRF_IDX_W-1:0]       disp_opa_tag_i,
   input  logic                       disp_opa_rdy_i,
   input  logic [PRF_IDX_W-1:0]       disp_opb_tag_i,
   input  logic                       disp_opb_rdy_i,
   input  logic [ROB_IDX_W:0]         disp_rob_idx_i,
   input  logic [BR_MASK_W-1:0]       disp_br_mask_i,
   input  logic                       cdb_valid_i,
   input  logic [PRF_IDX_W-1:0]       cdb_tag_i,
   input  logic                       rob_br_recovery_i,
   input  logic [BR_MASK_W-1:0]       rob_br_tag_fix_i,
   input  logic                       br_ok_i,
   input  logic [BR_MASK_W-1:0]       br_ok_tag_i,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       iss_start_o,
   output logic [63:0]                iss_npc_o,
   output logic [31:0]                iss_inst_o,
   output logic [PRF_IDX_W-1:0]       iss_dest_tag_o,
   output logic [PRF_IDX_W-1:0]       iss_opa_tag_o,
   output logic [PRF_IDX_W-1:0]       iss_opb_tag_o,
   output logic [ROB_IDX_W:0]         iss_rob_idx_o,
   output logic [BR_MASK_W-1:0]       iss_br_mask_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [CNT_W-1:0]     head_q, head_d, tail_q, tail_d;
   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [DEPTH-1:0]     opa_rdy_q, opa_rdy_d, opb_rdy_q, opb_rdy_d;
   logic [63:0]          npc_q [DEPTH];
   logic [63:0]          npc_d [DEPTH];
   logic [31:0]          inst_q [DEPTH];
   logic [31:0]          inst_d [DEPTH];
   logic [PRF_IDX_W-1:0] dest_q [DEPTH];
   logic [PRF_IDX_W-1:0] dest_d [DEPTH];
   logic [PRF_IDX_W-1:0] opa_tag_q [DEPTH];
   logic [PRF_IDX_W-1:0] opa_tag_d [DEPTH];
   logic [PRF_IDX_W-1:0] opb_tag_q [DEPTH];
   logic [PRF_IDX_W-1:0] opb_tag_d [DEPTH];
   logic [ROB_IDX_W:0]   rob_q [DEPTH];
   logic [ROB_IDX_W:0]   rob_d [DEPTH];
   logic [BR_MASK_W-1:0] mask_q [DEPTH];
   logic [BR_MASK_W-1:0] mask_d [DEPTH];

   logic                 iss_start_q, iss_start_d;
   logic [63:0]          iss_npc_q, iss_npc_d;
   logic [31:0]          iss_inst_q, iss_inst_d;
   logic [PRF_IDX_W-1:0] iss_dest_q, iss_dest_d;
   logic [PRF_IDX_W-1:0] iss_opa_q, iss_opa_d;
   logic [PRF_IDX_W-1:0] iss_opb_q, iss_opb_d;
   logic [ROB_IDX_W:0]   iss_rob_q, iss_rob_d;
   logic [BR_MASK_W-1:0] iss_mask_q, iss_mask_d;

   logic [CNT_W-1:0]     cnt;
   logic [PTR_W-1:0]     head_idx, tail_idx, idx;
   logic [BR_MASK_W-1:0] ok_clr;
   logic [DEPTH-1:0]     kill;
   logic                 hit, issue_ok, enq;
   logic [CNT_W-1:0]     rec_tail;

   assign cnt     = tail_q - head_q;
   assign count_o = cnt;
   assign full_o  = (cnt == CNT_W'(DEPTH));

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      valid_d     = valid_q;
      opa_rdy_d   = opa_rdy_q;
      opb_rdy_d   = opb_rdy_q;
      npc_d       = npc_q;
      inst_d      = inst_q;
      dest_d      = dest_q;
      opa_tag_d   = opa_tag_q;
      opb_tag_d   = opb_tag_q;
      rob_d       = rob_q;
      mask_d      = mask_q;
      iss_start_d = 1'b0;
      iss_npc_d   = iss_npc_q;
      iss_inst_d  = iss_inst_q;
      iss_dest_d  = iss_dest_q;
      iss_opa_d   = iss_opa_q;
      iss_opb_d   = iss_opb_q;
      iss_rob_d   = iss_rob_q;
      head_idx    = head_q[PTR_W-1:0];
      tail_idx    = tail_q[PTR_W-1:0];
      idx         = '0;
      ok_clr      = br_ok_i ? br_ok_tag_i : '0;
      iss_mask_d  = iss_mask_q & ~ok_clr;
      kill        = '0;
      hit         = 1'b0;
      rec_tail    = tail_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (cdb_valid_i && cdb_tag_i == opa_tag_q[i]) opa_rdy_d[i] = 1'b1;
         if (cdb_valid_i && cdb_tag_i == opb_tag_q[i]) opb_rdy_d[i] = 1'b1;
      end

      // Walk oldest to youngest; everything from the first squashed entry on is dropped.
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_idx + PTR_W'(k);
         if (CNT_W'(k) < cnt) begin
            if (!hit && rob_br_recovery_i && valid_q[idx] &&
                (mask_q[idx] & rob_br_tag_fix_i) != '0) begin
               hit      = 1'b1;
               rec_tail = head_q + CNT_W'(k);
            end
            if (hit) kill[idx] = 1'b1;
         end
      end

      issue_ok = (cnt != '0) && valid_q[head_idx] && opa_rdy_d[head_idx] &&
                 opb_rdy_d[head_idx] && !kill[head_idx];

      valid_d = valid_q & ~kill;
      for (int i = 0; i < DEPTH; i++) mask_d[i] = mask_q[i] & ~ok_clr;

      if (issue_ok) begin
         valid_d[head_idx] = 1'b0;
         head_d            = head_q + 1'b1;
         iss_start_d       = 1'b1;
         iss_npc_d         = npc_q[head_idx];
         iss_inst_d        = inst_q[head_idx];
         iss_dest_d        = dest_q[head_idx];
         iss_opa_d         = opa_tag_q[head_idx];
         iss_opb_d         = opb_tag_q[head_idx];
         iss_rob_d         = rob_q[head_idx];
         iss_mask_d        = mask_q[head_idx] & ~ok_clr;
      end

      if (rob_br_recovery_i) tail_d = rec_tail;

      enq = disp_en_i && !full_o && !rob_br_recovery_i;
      if (enq) begin
         valid_d[tail_idx]   = 1'b1;
         npc_d[tail_idx]     = disp_npc_i;
         inst_d[tail_idx]    = disp_inst_i;
         dest_d[tail_idx]    = disp_dest_tag_i;
         opa_tag_d[tail_idx] = disp_opa_tag_i;
         opb_tag_d[tail_idx] = disp_opb_tag_i;
         opa_rdy_d[tail_idx] = disp_opa_rdy_i | (cdb_valid_i && cdb_tag_i == disp_opa_tag_i);
         opb_rdy_d[tail_idx] = disp_opb_rdy_i | (cdb_valid_i && cdb_tag_i == disp_opb_tag_i);
         rob_d[tail_idx]     = disp_rob_idx_i;
         mask_d[tail_idx]    = disp_br_mask_i & ~ok_clr;
         tail_d              = tail_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         valid_q     <= '0;
         opa_rdy_q   <= '0;
         opb_rdy_q   <= '0;
         iss_start_q <= 1'b0;
         iss_npc_q   <= '0;
         iss_inst_q  <= '0;
         iss_dest_q  <= '0;
         iss_opa_q   <= '0;
         iss_opb_q   <= '0;
         iss_rob_q   <= '0;
         iss_mask_q  <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         valid_q     <= valid_d;
         opa_rdy_q   <= opa_rdy_d;
         opb_rdy_q   <= opb_rdy_d;
         iss_start_q <= iss_start_d;
         iss_npc_q   <= iss_npc_d;
         iss_inst_q  <= iss_inst_d;
         iss_dest_q  <= iss_dest_d;
         iss_opa_q   <= iss_opa_d;
         iss_opb_q   <= iss_opb_d;
         iss_rob_q   <= iss_rob_d;
         iss_mask_q  <= iss_mask_d;
      end
   end

   // Payload storage is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      npc_q     <= npc_d;
      inst_q    <= inst_d;
      dest_q    <= dest_d;
      opa_tag_q <= opa_tag_d;
      opb_tag_q <= opb_tag_d;
      rob_q     <= rob_d;
      mask_q    <= mask_d;
   end

   assign iss_start_o    = iss_start_q;
   assign iss_npc_o      = iss_npc_q;
   assign iss_inst_o     = iss_inst_q;
   assign iss_dest_tag_o = iss_dest_q;
   assign iss_opa_tag_o  = iss_opa_q;
   assign iss_opb_tag_o  = iss_opb_q;
   assign iss_rob_idx_o  = iss_rob_q;
   assign iss_br_mask_o  = iss_mask_q;

endmodule
